// File: rtl/tape_arb_pkg.sv
// Shared types and default widths for the tape RAM arbiter and cpu_core.
package tape_arb_pkg;

  localparam int TAPE_ADDR_W    = 12;
  localparam int TAPE_DATA_W    = 8;
  localparam int TAPE_DEPTH_DEF = 4096;

  typedef enum logic {
    S_ARB,
    S_CLEAR
  } arb_state_t;

  typedef enum logic [1:0] {
    G_NONE,
    G_CPU,
    G_VGA,
    G_CLR
  } gnt_src_t;

endpackage

// File: rtl/tape_clear_seq.sv
// Zero-fill address sequencer: walks clr_ptr from 0 to TAPE_DEPTH-1 after start,
// then pulses done for one cycle.
module tape_clear_seq
  import tape_arb_pkg::*;
#(
  parameter int ADDR_W     = TAPE_ADDR_W,
  parameter int TAPE_DEPTH = TAPE_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  output logic              active,
  output logic              last,
  output logic              done,
  output logic [ADDR_W-1:0] fill_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TAPE_DEPTH - 1);

  logic [ADDR_W-1:0] clr_ptr;

  assign fill_addr = clr_ptr;
  assign last      = active && (clr_ptr == LAST_ADDR);

  // start is ignored while active so a re-request cannot restart the fill
  always_ff @(posedge clk) begin
    if (!resetn) begin
      active  <= 1'b0;
      done    <= 1'b0;
      clr_ptr <= '0;
    end else begin
      done <= 1'b0;
      if (active) begin
        if (clr_ptr == LAST_ADDR) begin
          active  <= 1'b0;
          done    <= 1'b1;
          clr_ptr <= '0;
        end else begin
          clr_ptr <= clr_ptr + ADDR_W'(1);
        end
      end else if (start) begin
        active  <= 1'b1;
        clr_ptr <= '0;
      end
    end
  end

endmodule

// File: rtl/tape_arbiter.sv
// Single-port tape RAM arbiter: CPU (r/w), VGA (read) and a zero-fill sequencer.
// Optional VGA starvation guard enabled by defining TAPE_ARB_STARVE_GUARD_EN.
module tape_arbiter
  import tape_arb_pkg::*;
#(
  parameter int ADDR_W       = TAPE_ADDR_W,
  parameter int TAPE_DEPTH   = TAPE_DEPTH_DEF,
  parameter int VGA_MAX_WAIT = 7
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   clear_req,
  output logic                   clear_busy,
  output logic                   clear_done,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [ADDR_W-1:0]      cpu_addr,
  input  logic [TAPE_DATA_W-1:0] cpu_wdata,
  output logic                   cpu_gnt,
  output logic                   cpu_rvalid,
  output logic [TAPE_DATA_W-1:0] cpu_rdata,
  input  logic                   vga_req,
  input  logic [ADDR_W-1:0]      vga_addr,
  output logic                   vga_gnt,
  output logic                   vga_rvalid,
  output logic [TAPE_DATA_W-1:0] vga_rdata,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic                   mem_we,
  output logic [TAPE_DATA_W-1:0] mem_wdata,
  input  logic [TAPE_DATA_W-1:0] mem_rdata
);

  if (TAPE_DEPTH < 1 || TAPE_DEPTH > 2 ** ADDR_W) begin : g_bad_depth
    $error("tape_arbiter: TAPE_DEPTH must be in 1..2**ADDR_W");
  end
  if (VGA_MAX_WAIT < 1) begin : g_bad_wait
    $error("tape_arbiter: VGA_MAX_WAIT must be >= 1");
  end

  arb_state_t        state, state_nxt;
  gnt_src_t          src;
  logic              clear_start;
  logic              fill_active;
  logic              fill_last;
  logic              vga_force;
  logic [ADDR_W-1:0] fill_addr;

  assign clear_start = (state == S_ARB) && clear_req;
  assign clear_busy  = fill_active;

  tape_clear_seq #(
    .ADDR_W     (ADDR_W),
    .TAPE_DEPTH (TAPE_DEPTH)
  ) u_clear_seq (
    .clk       (clk),
    .resetn    (resetn),
    .start     (clear_start),
    .active    (fill_active),
    .last      (fill_last),
    .done      (clear_done),
    .fill_addr (fill_addr)
  );

`ifdef TAPE_ARB_STARVE_GUARD_EN
  localparam int                WAIT_W   = $clog2(VGA_MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(VGA_MAX_WAIT);

  logic [WAIT_W-1:0] wait_cnt;

  assign vga_force = vga_req && (wait_cnt == WAIT_MAX);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wait_cnt <= '0;
    end else if (clear_start || !vga_req || vga_gnt) begin
      wait_cnt <= '0;
    end else if (state == S_ARB && wait_cnt != WAIT_MAX) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end
`else
  assign vga_force = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_ARB;
      cpu_rvalid <= 1'b0;
      vga_rvalid <= 1'b0;
    end else begin
      state      <= state_nxt;
      cpu_rvalid <= cpu_gnt && !cpu_we;
      vga_rvalid <= vga_gnt;
    end
  end

  // The cycle that samples clear_req still arbitrates normally.
  always_comb begin
    state_nxt = state;
    src       = G_NONE;
    case (state)
      S_ARB: begin
        if (vga_force)    src = G_VGA;
        else if (cpu_req) src = G_CPU;
        else if (vga_req) src = G_VGA;
        if (clear_req) state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        src = G_CLR;
        if (fill_last) state_nxt = S_ARB;
      end
      default: state_nxt = S_ARB;
    endcase
    if (!resetn) src = G_NONE;
  end

  always_comb begin
    cpu_gnt   = 1'b0;
    vga_gnt   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (src)
      G_CPU: begin
        cpu_gnt   = 1'b1;
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
      G_VGA: begin
        vga_gnt   = 1'b1;
        mem_addr  = vga_addr;
        mem_wdata = cpu_wdata;
      end
      G_CLR: begin
        mem_we    = 1'b1;
        mem_addr  = fill_addr;
      end
      default: ;
    endcase
  end

  assign cpu_rdata = mem_rdata;
  assign vga_rdata = mem_rdata;

endmodule

// File: tb/tb_tape_arbiter.sv
// Self-checking bench for tape_arbiter with a behavioural synchronous-read RAM.
`timescale 1ns/1ps
module tb_tape_arbiter;

  localparam int AW    = 12;
  localparam int DEPTH = 4096;
  localparam int MAXW  = 7;
`ifdef TAPE_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk, resetn, clear_req, clear_busy, clear_done;
  logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [AW-1:0] cpu_addr, vga_addr, mem_addr;
  logic [7:0]    cpu_wdata, cpu_rdata, vga_rdata, mem_wdata, mem_rdata;
  logic          vga_req, vga_gnt, vga_rvalid, mem_we;

  logic [7:0] ram   [0:DEPTH-1];
  logic [7:0] model [0:DEPTH-1];
  int total = 0;
  int bad   = 0;

  tape_arbiter #(.ADDR_W(AW), .TAPE_DEPTH(DEPTH), .VGA_MAX_WAIT(MAXW)) dut (
    .clk(clk), .resetn(resetn), .clear_req(clear_req), .clear_busy(clear_busy),
    .clear_done(clear_done), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .cpu_rdata(cpu_rdata), .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
    .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_req = 1'b0; cpu_we = 1'b0; vga_req = 1'b0; clear_req = 1'b0;
    cpu_addr = '0; vga_addr = '0; cpu_wdata = '0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h005; vga_req = 1'b1;
    tick(); tick();
    total++; if (cpu_gnt !== 1'b0) begin bad++; $display("FAIL rst_cpu_gnt got=%b exp=0", cpu_gnt); end
    total++; if (vga_gnt !== 1'b0) begin bad++; $display("FAIL rst_vga_gnt got=%b exp=0", vga_gnt); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we got=%b exp=0", mem_we); end
    total++; if (clear_busy !== 1'b0 || clear_done !== 1'b0) begin
      bad++; $display("FAIL rst_clear got=%b%b exp=00", clear_busy, clear_done); end
    total++; if (cpu_rvalid !== 1'b0 || vga_rvalid !== 1'b0) begin
      bad++; $display("FAIL rst_rvalid got=%b%b exp=00", cpu_rvalid, vga_rvalid); end
    resetn = 1'b1; idle();
    tick();
  endtask

  task automatic test_write_read();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h005; cpu_wdata = 8'h2A;
    #1;
    total++; if (cpu_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 12'h005 || mem_wdata !== 8'h2A) begin
      bad++; $display("FAIL wr_grant got gnt=%b we=%b a=%h d=%h exp 1 1 005 2a", cpu_gnt, mem_we, mem_addr, mem_wdata); end
    tick(); model[5] = 8'h2A;
    cpu_we = 1'b0;
    #1;
    total++; if (cpu_gnt !== 1'b1 || mem_we !== 1'b0 || cpu_rvalid !== 1'b0) begin
      bad++; $display("FAIL rd_grant got gnt=%b we=%b rv=%b exp 1 0 0", cpu_gnt, mem_we, cpu_rvalid); end
    tick(); idle();
    #1;
    total++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h2A) begin
      bad++; $display("FAIL rd_data got rv=%b d=%h exp 1 2a", cpu_rvalid, cpu_rdata); end
    total++; if (vga_rvalid !== 1'b0) begin bad++; $display("FAIL rd_vga_rv got=%b exp=0", vga_rvalid); end
    tick();
  endtask

  // Both held: guard off -> CPU always; guard on -> VGA every (MAXW+1)th cycle.
  task automatic test_starve();
    bit prev_c = 1'b0, prev_v = 1'b0, exp_v;
    logic [AW-1:0] prev_a = '0;
    idle();
    vga_req = 1'b1; vga_addr = 12'h123; cpu_req = 1'b1; cpu_we = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      cpu_addr = AW'(i);
      #1;
      exp_v = GUARD && (i % (MAXW + 1) == 0);
      total++; if (vga_gnt !== exp_v || cpu_gnt !== !exp_v) begin
        bad++; $display("FAIL starve_gnt cyc=%0d got cpu=%b vga=%b exp cpu=%b vga=%b", i, cpu_gnt, vga_gnt, !exp_v, exp_v); end
      total++; if (vga_rvalid !== prev_v || cpu_rvalid !== prev_c) begin
        bad++; $display("FAIL starve_rv cyc=%0d got c=%b v=%b exp c=%b v=%b", i, cpu_rvalid, vga_rvalid, prev_c, prev_v); end
      if (prev_v) begin
        total++; if (vga_rdata !== model[12'h123]) begin
          bad++; $display("FAIL starve_vdata got=%h exp=%h", vga_rdata, model[12'h123]); end
      end else if (prev_c) begin
        total++; if (cpu_rdata !== model[prev_a]) begin
          bad++; $display("FAIL starve_cdata got=%h exp=%h", cpu_rdata, model[prev_a]); end
      end
      prev_v = exp_v; prev_c = !exp_v; prev_a = cpu_addr;
      tick();
    end
    idle(); tick();
  endtask

  task automatic test_random();
    int denied = 0;
    bit ec, ev, force_v, prev_c = 1'b0, prev_v = 1'b0;
    logic [7:0]    prev_d = '0;
    logic [AW-1:0] ea;
    logic [7:0]    ed;
    for (int i = 0; i < 400; i++) begin
      cpu_req   = ($urandom % 4) != 0;
      cpu_we    = $urandom % 2;
      cpu_addr  = AW'($urandom % 16);
      cpu_wdata = 8'($urandom);
      vga_req   = $urandom % 2;
      vga_addr  = AW'($urandom % 16);
      #1;
      force_v = GUARD && vga_req && (denied == MAXW);
      ec = cpu_req && !force_v;
      ev = vga_req && !ec;
      ea = ec ? cpu_addr : (ev ? vga_addr : '0);
      ed = (ec || ev) ? cpu_wdata : 8'h00;
      total++; if (cpu_gnt !== ec || vga_gnt !== ev) begin
        bad++; $display("FAIL rnd_gnt i=%0d got c=%b v=%b exp c=%b v=%b", i, cpu_gnt, vga_gnt, ec, ev); end
      total++; if (mem_addr !== ea || mem_wdata !== ed || mem_we !== (ec && cpu_we)) begin
        bad++; $display("FAIL rnd_port i=%0d got a=%h d=%h we=%b exp a=%h d=%h we=%b",
                        i, mem_addr, mem_wdata, mem_we, ea, ed, ec && cpu_we); end
      total++; if (cpu_rvalid !== prev_c || vga_rvalid !== prev_v) begin
        bad++; $display("FAIL rnd_rv i=%0d got c=%b v=%b exp c=%b v=%b", i, cpu_rvalid, vga_rvalid, prev_c, prev_v); end
      if (prev_c || prev_v) begin
        total++; if (cpu_rdata !== prev_d || vga_rdata !== prev_d) begin
          bad++; $display("FAIL rnd_rdata i=%0d got=%h exp=%h", i, cpu_rdata, prev_d); end
      end
      prev_c = ec && !cpu_we;
      prev_v = ev;
      prev_d = ec ? model[cpu_addr] : model[vga_addr];
      if (ec && cpu_we) model[cpu_addr] = cpu_wdata;
      if (!vga_req || ev) denied = 0;
      else if (denied < MAXW) denied++;
      tick();
    end
    idle(); tick();
  endtask

  task automatic test_clear(input bit reassert);
    logic [AW-1:0] cells [3];
    int busy_cnt = 0, gnt_cnt = 0, port_err = 0;
    cells[0] = 12'h000; cells[1] = 12'h7FF; cells[2] = 12'hFFF;
    idle();
    for (int j = 0; j < 3; j++) begin
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = cells[j]; cpu_wdata = 8'hFF;
      #1;
      total++; if (cpu_gnt !== 1'b1) begin bad++; $display("FAIL clr_preload got=%b exp=1", cpu_gnt); end
      model[cells[j]] = 8'hFF;
      tick();
    end
    idle(); clear_req = 1'b1;
    #1;
    total++; if (clear_busy !== 1'b0) begin bad++; $display("FAIL clr_busy_n got=%b exp=0", clear_busy); end
    tick();
    clear_req = 1'b0; cpu_req = 1'b1; cpu_addr = 12'h007; vga_req = 1'b1; vga_addr = 12'h009;
    for (int k = 1; k <= DEPTH; k++) begin
      clear_req = reassert && (k == 2000);
      #1;
      if (clear_busy === 1'b1) busy_cnt++;
      if (cpu_gnt !== 1'b0 || vga_gnt !== 1'b0) gnt_cnt++;
      if (mem_we !== 1'b1 || mem_addr !== AW'(k - 1) || mem_wdata !== 8'h00 || clear_done !== 1'b0) port_err++;
      tick();
    end
    for (int a = 0; a < DEPTH; a++) model[a] = 8'h00;
    idle();
    #1;
    total++; if (busy_cnt != DEPTH) begin bad++; $display("FAIL clr_busy_len got=%0d exp=%0d", busy_cnt, DEPTH); end
    total++; if (gnt_cnt != 0) begin bad++; $display("FAIL clr_grants got=%0d exp=0", gnt_cnt); end
    total++; if (port_err != 0) begin bad++; $display("FAIL clr_port_errs got=%0d exp=0", port_err); end
    total++; if (clear_done !== 1'b1 || clear_busy !== 1'b0) begin
      bad++; $display("FAIL clr_done got done=%b busy=%b exp 1 0", clear_done, clear_busy); end
    tick();
    total++; if (clear_done !== 1'b0) begin bad++; $display("FAIL clr_done_pulse got=%b exp=0", clear_done); end
    for (int j = 0; j < 3; j++) begin
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = cells[j];
      tick(); idle();
      #1;
      total++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== model[cells[j]]) begin
        bad++; $display("FAIL clr_readback a=%h got rv=%b d=%h exp 1 %h", cells[j], cpu_rvalid, cpu_rdata, model[cells[j]]); end
      tick();
    end
  endtask

  task automatic test_reset_mid_fill();
    idle();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h200; cpu_wdata = 8'h33; tick(); model[12'h200] = 8'h33;
    cpu_addr = 12'h010; cpu_wdata = 8'h44; tick(); model[12'h010] = 8'h44;
    idle(); clear_req = 1'b1; tick(); clear_req = 1'b0;
    for (int k = 1; k < 100; k++) tick();
    for (int a = 0; a < 99; a++) model[a] = 8'h00;
    resetn = 1'b0; cpu_req = 1'b1; vga_req = 1'b1;
    #1;
    total++; if (cpu_gnt !== 1'b0 || vga_gnt !== 1'b0 || mem_we !== 1'b0) begin
      bad++; $display("FAIL midrst_force got c=%b v=%b we=%b exp 0 0 0", cpu_gnt, vga_gnt, mem_we); end
    tick();
    resetn = 1'b1; vga_req = 1'b0; cpu_we = 1'b0; cpu_addr = 12'h200;
    #1;
    total++; if (clear_busy !== 1'b0 || clear_done !== 1'b0) begin
      bad++; $display("FAIL midrst_clear got busy=%b done=%b exp 0 0", clear_busy, clear_done); end
    total++; if (cpu_gnt !== 1'b1) begin bad++; $display("FAIL midrst_gnt got=%b exp=1", cpu_gnt); end
    tick(); cpu_addr = 12'h010;
    #1;
    total++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== model[12'h200]) begin
      bad++; $display("FAIL midrst_rd200 got rv=%b d=%h exp 1 %h", cpu_rvalid, cpu_rdata, model[12'h200]); end
    tick(); idle();
    #1;
    total++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== model[12'h010]) begin
      bad++; $display("FAIL midrst_rd010 got rv=%b d=%h exp 1 %h", cpu_rvalid, cpu_rdata, model[12'h010]); end
    tick();
  endtask

  initial begin
    resetn = 1'b0;
    idle();
    for (int a = 0; a < DEPTH; a++) begin
      ram[a]   = 8'($urandom);
      model[a] = ram[a];
    end
    test_reset();
    test_write_read();
    test_starve();
    test_random();
    test_clear(1'b0);
    test_clear(1'b1);
    test_reset_mid_fill();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tape_arbiter.md
# tape_arbiter

Single-port access controller for the 8-bit brainfuck data tape RAM. It shares one synchronous-read RAM port between the CPU core (read/write), the VGA tape viewer (read-only), and an internal zero-fill sequencer that clears the tape before a run. It sits between `cpu_core`'s tape accesses and the tape RAM instance, replacing direct dual-port access.

## Interface

Parameters:
- `ADDR_W`, 12: tape address width.
- `TAPE_DEPTH`, 4096: cells cleared by zero-fill; must be ≤ 2**ADDR_W.
- `VGA_MAX_WAIT`, 7: consecutive denied VGA cycles before VGA is forced ahead of the CPU. Used only with the starvation guard; must be ≥ 1.

Ports:
- `clk`, in, 1: the single clock.
- `resetn`, in, 1: **synchronous, active-low** reset.
- `clear_req`, in, 1: start the zero-fill. Level sampled in `S_ARB`.
- `clear_busy`, out, 1: zero-fill in progress.
- `clear_done`, out, 1: one-cycle pulse after the last fill write.
- `cpu_req`, `cpu_we`, in, 1 each: CPU access request and write select.
- `cpu_addr`, in, ADDR_W; `cpu_wdata`, in, 8: CPU address and write data.
- `cpu_gnt`, out, 1: CPU access accepted this cycle (combinational).
- `cpu_rvalid`, out, 1; `cpu_rdata`, out, 8: read data return.
- `vga_req`, in, 1; `vga_addr`, in, ADDR_W: VGA read request.
- `vga_gnt`, `vga_rvalid`, out, 1 each; `vga_rdata`, out, 8: VGA grant and read return.
- `mem_addr`, out, ADDR_W; `mem_we`, out, 1; `mem_wdata`, out, 8: RAM port drive (combinational).
- `mem_rdata`, in, 8: RAM read data, valid one cycle after the address edge.

## Operation

- States (`tape_arb_pkg::arb_state_t`):
  - `S_ARB`: normal arbitration.
  - `S_CLEAR`: zero-fill.
- In `S_ARB`, at most one grant per cycle.
  - Default priority: CPU over VGA.
  - Guard override: VGA wins when `wait_cnt == VGA_MAX_WAIT` and `vga_req` is high.
- The granted requester drives the RAM port:
  - `mem_addr` = requester address.
  - `mem_we` = `cpu_we` for the CPU, 0 for VGA.
  - `mem_wdata` = `cpu_wdata`.
- With no grant: `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- `wait_cnt` behaviour:
  - Increments, saturating at `VGA_MAX_WAIT`, each `S_ARB` cycle with `vga_req && !vga_gnt`.
  - Clears on `vga_gnt`, on `!vga_req`, and on entering `S_CLEAR`.
- `clear_req` high in `S_ARB`:
  - The current cycle's arbitration still completes.
  - Next state is `S_CLEAR` with `clr_ptr`=0 and `clear_busy`=1.
- `S_CLEAR`:
  - Both grants are 0; requests are held off, not queued.
  - Each cycle drives `mem_we`=1, `mem_addr`=`clr_ptr`, `mem_wdata`=0, then `clr_ptr`++.
  - When `clr_ptr == TAPE_DEPTH-1`, it writes that cell, returns to `S_ARB`, sets `clear_busy`=0, and pulses `clear_done`=1 for one cycle.
- `clear_req` during `S_CLEAR` is ignored; it does not restart or extend the fill.
- Read return:
  - `cpu_rvalid` is registered: `cpu_gnt && !cpu_we` from the previous cycle. `vga_rvalid` is likewise registered from `vga_gnt`.
  - `cpu_rdata` = `vga_rdata` = `mem_rdata` (pass-through). Each is meaningful only while its rvalid is high.
- Writes produce no rvalid.
- Reset (any cycle, including mid-fill), sampled at the posedge with `resetn`=0:
  - State → `S_ARB`; `clr_ptr`, `wait_cnt`, `cpu_rvalid`, `vga_rvalid`, `clear_busy`, `clear_done` → 0.
  - Any partial fill is abandoned.
  - During reset, grants are forced 0 and `mem_we`=0.

## Timing

- Grant: same cycle as request (combinational). A requester holds `req`/`addr` until it sees `gnt`.
- Read latency: data and rvalid arrive exactly 1 cycle after the grant cycle. Back-to-back reads give one result per cycle.
- Write: committed at the grant-cycle posedge.
- Zero-fill: `clear_req` sampled at edge N → fill writes in cycles N+1 … N+TAPE_DEPTH → `clear_done` high in cycle N+TAPE_DEPTH+1. `clear_busy` is high for cycles N+1 … N+TAPE_DEPTH.
- Worst-case VGA latency with the guard: VGA_MAX_WAIT+1 cycles in `S_ARB`.

## Configuration

- `TAPE_ARB_STARVE_GUARD_EN` defined: `wait_cnt` and the VGA override are present as described.
- Undefined:
  - Strict CPU-over-VGA priority; VGA may starve indefinitely under continuous `cpu_req`.
  - `wait_cnt` is not instantiated.
  - `VGA_MAX_WAIT` is unused.

## Structure

- `tape_arb_pkg` holds:
  - `arb_state_t` (`S_ARB`, `S_CLEAR`).
  - `gnt_src_t` (`G_NONE`, `G_CPU`, `G_VGA`, `G_CLR`).
  - Default-width localparams shared with `cpu_core`.
- One sub-module, `tape_clear_seq`: holds `clr_ptr`, the `TAPE_DEPTH` terminal compare, `clear_busy` and `clear_done`. It takes `start` and outputs `active` and the fill address.
- Arbitration mux, `wait_cnt` and the rvalid registers stay in `tape_arbiter`.

## Test plan

- CPU write 0x2A @0x005, then CPU read @0x005 → `cpu_gnt` on both; `cpu_rvalid`=1 with `cpu_rdata`=0x2A one cycle after the read grant.
- `cpu_req` and `vga_req` held together (guard off) → `cpu_gnt` every cycle, `vga_gnt`=0 throughout.
- Same stimulus with the guard on, `VGA_MAX_WAIT`=7 → `vga_gnt` on the 8th cycle, then CPU again; `vga_rvalid` one cycle later.
- Preload 0xFF at 0x000, 0x7FF and 0xFFF; pulse `clear_req` (TAPE_DEPTH=4096):
  - `clear_busy` for exactly 4096 cycles; `clear_done` pulse at N+4097.
  - No grants during the fill; all three cells read back 0x00.
- `clear_req` re-asserted mid-fill → `clear_done` still at N+4097.
- `resetn`=0 at fill cycle 100 → next cycle `clear_busy`=0, state `S_ARB`; a subsequent CPU read is granted immediately.
